// File: rtl/bit_scan_iter.sv
// bit_scan_iter: enumerates set-bit indices of a word, lowest first, one beat per handshake
module ctz #(
  parameter int ORDER = 3
) (
  input  logic [2**ORDER-1:0] word,
  output logic [ORDER-1:0]    idx
);
  // lowest set bit wins because it is assigned last; zero word yields 0
  always_comb begin
    idx = '0;
    for (int i = 2**ORDER-1; i >= 0; i--) idx = word[i] ? ORDER'(i) : idx;
  end
endmodule

module bit_scan_iter #(
  parameter int ORDER = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2**ORDER-1:0] in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ORDER-1:0]   out_index,
  output logic [ORDER:0]     out_seq,
  output logic               out_last,
  output logic               out_none
);
  localparam int W = 2**ORDER;
  typedef enum logic {IDLE, SCAN} state_t;
  state_t state, state_n;
  logic [W-1:0] word, word_n, word_clr;
  logic [ORDER:0] seq, seq_n;
  logic [ORDER-1:0] low;
  logic fire, take;
  ctz #(.ORDER(ORDER)) u_ctz (.word(word), .idx(low));
  assign word_clr  = word & (word - W'(1));
  assign out_valid = state == SCAN;
  assign out_index = out_valid ? low : '0;
  assign out_seq   = out_valid ? seq : '0;
  assign out_last  = out_valid & (word_clr == '0);
  assign out_none  = out_valid & (word == '0);
  assign fire      = out_valid & out_ready;
  assign in_ready  = (state == IDLE) | (fire & out_last);
  assign take      = in_valid & in_ready;
  // next state: accept a new word (also on last-beat handoff), else consume a beat
  always_comb begin
    state_n = state;
    word_n  = word;
    seq_n   = seq;
    if (take) begin
      state_n = SCAN;
      word_n  = in;
      seq_n   = '0;
    end else if (fire) begin
      state_n = out_last ? IDLE : SCAN;
      word_n  = word_clr;
      seq_n   = out_last ? '0 : seq + (ORDER+1)'(1);
    end
  end
  // state, held word and beat ordinal registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      word  <= '0;
      seq   <= '0;
    end else begin
      state <= state_n;
      word  <= word_n;
      seq   <= seq_n;
    end
  end
endmodule

// File: tb/tb_bit_scan_iter.sv
// tb_bit_scan_iter: directed checks of bit_scan_iter with hand-computed beats
module tb_bit_scan_iter;
  logic clock = 0, reset = 1, in_valid = 0, out_ready = 1;
  logic [7:0] in = 0;
  logic in_ready, out_valid, out_last, out_none;
  logic [2:0] out_index;
  logic [3:0] out_seq;
  int checks = 0, failures = 0;

  bit_scan_iter #(.ORDER(3)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in(in),
    .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index),
    .out_seq(out_seq), .out_last(out_last), .out_none(out_none)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic send(input logic [7:0] w, input bit hold);
    in = w;
    in_valid = 1;
    check("in_ready_accept", int'(in_ready), 1);
    step();
    if (!hold) in_valid = 0;
  endtask

  task automatic beat(input string tag, input int idx, input int sq, input int last, input int none);
    check({tag, "_valid"}, int'(out_valid), 1);
    check({tag, "_index"}, int'(out_index), idx);
    check({tag, "_seq"}, int'(out_seq), sq);
    check({tag, "_last"}, int'(out_last), last);
    check({tag, "_none"}, int'(out_none), none);
    step();
  endtask

  task automatic idle(input string tag);
    check({tag, "_idle_valid"}, int'(out_valid), 0);
    check({tag, "_idle_ready"}, int'(in_ready), 1);
  endtask

  initial begin
    @(negedge clock);
    check("rst_valid", int'(out_valid), 0);
    check("rst_last", int'(out_last), 0);
    check("rst_none", int'(out_none), 0);
    check("rst_index", int'(out_index), 0);
    check("rst_seq", int'(out_seq), 0);
    reset = 0;
    step();
    idle("post_rst");
    send(8'h29, 0);
    beat("w29_b0", 0, 0, 0, 0);
    beat("w29_b1", 3, 1, 0, 0);
    check("w29_last_ready", int'(in_ready), 1);
    beat("w29_b2", 5, 2, 1, 0);
    idle("w29");
    send(8'h00, 0);
    beat("w00", 0, 0, 1, 1);
    idle("w00");
    send(8'hFF, 0);
    for (int i = 0; i < 8; i++) beat($sformatf("wff_b%0d", i), i, i, i == 7, 0);
    idle("wff");
    send(8'h14, 0);
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      check("w14_stall_ready", int'(in_ready), 0);
      beat($sformatf("w14_stall%0d", i), 2, 0, 0, 0);
    end
    out_ready = 1;
    beat("w14_b0", 2, 0, 0, 0);
    beat("w14_b1", 4, 1, 1, 0);
    idle("w14");
    send(8'h80, 1);
    in = 8'h01;
    check("handoff_ready", int'(in_ready), 1);
    beat("w80", 7, 0, 1, 0);
    in_valid = 0;
    check("w01_ready", int'(in_ready), 1);
    beat("w01", 0, 0, 1, 0);
    idle("w01");
    send(8'hFF, 0);
    beat("rst_b0", 0, 0, 0, 0);
    beat("rst_b1", 1, 1, 0, 0);
    #2 reset = 1;
    #1;
    check("async_valid", int'(out_valid), 0);
    check("async_index", int'(out_index), 0);
    check("async_seq", int'(out_seq), 0);
    check("async_last", int'(out_last), 0);
    @(negedge clock);
    reset = 0;
    step();
    idle("after_rst");
    send(8'h02, 0);
    beat("w02", 1, 0, 1, 0);
    idle("w02");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
